vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Consumes the 25 MHz pixel-rate strobe produced by the pixel clock generator and turns it into VGA raster timing.
- Outputs: hsync, vsync, display-enable, pixel coordinates and frame/line start pulses.
- Runs entirely in the 100 MHz system clock domain. Advances one pixel per pix_ce strobe.
- Feeds the pixel pipeline and the VGA output pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low, 1 = active-high)
- CNT_W, 10, width of h_count/v_count
- CE_TIMEOUT, 8, max clk_in cycles between pix_ce strobes (monitor only)

Ports:
- clk_in  input  1  system clock, 100 MHz
- reset  input  1  synchronous reset, active-high
- pix_ce  input  1  pixel strobe, one clk_in cycle wide per pixel
- h_count  output  CNT_W  current pixel column, 0..H_TOTAL-1
- v_count  output  CNT_W  current line, 0..V_TOTAL-1
- hsync  output  1  horizontal sync, polarity per SYNC_POL
- vsync  output  1  vertical sync, polarity per SYNC_POL
- de  output  1  display enable, high in active region
- line_start  output  1  one-clk_in pulse when h_count becomes 0
- frame_start  output  1  one-clk_in pulse when (h_count, v_count) becomes (0, 0)
- ce_err  output  1  sticky pixel-strobe timeout flag (optional feature only; tied 0 otherwise)

Behaviour:
- Clock and reset: one clock, clk_in. Reset is synchronous and active-high; it is sampled on the clk_in rising edge and takes priority over pix_ce.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤ 2^CNT_W; this is checked by an elaboration-time assertion.
- Reset values:
  - h_count = H_TOTAL-1, v_count = V_TOTAL-1
  - hsync = vsync = inactive level (~SYNC_POL)
  - de = 0, line_start = 0, frame_start = 0, ce_err = 0
  - The reset point lies in back porch, so every output is consistent with the counters.
- Counter advance: only on clk_in edges where pix_ce = 1.
  - h_count increments; at H_TOTAL-1 it wraps to 0.
  - v_count increments only on the h wrap; at V_TOTAL-1 it wraps to 0 on that same edge.
  - With pix_ce = 0, all counters and decoded levels hold.
- Output registration: all outputs are registered and decoded from the next-state counter values, so hsync, vsync and de change on the same edge as the counters. There is zero cycles of skew between coordinates and control signals.
- Decode:
  - hsync active iff H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC (656..751 at defaults).
  - vsync active iff V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC (490..491); vsync follows v_count only.
  - de = (h < H_ACTIVE) && (v < V_ACTIVE).
- Pulses:
  - line_start = 1 for exactly the one clk_in cycle following the edge where h_count became 0.
  - frame_start is the same, additionally requiring v_count = 0; it coincides with a line_start.
  - Both pulses are 0 on every other cycle, including while pix_ce stays low.
- First strobe after reset: moves to (0, 0), asserts line_start and frame_start, sets de = 1.
- pix_ce held high on consecutive cycles is legal; the raster advances once per cycle.
- Reset asserted mid-frame: the next edge returns to the reset values, with no partial pulses.

Optional Feature:
- Macro VGA_TIMING_CE_MONITOR_EN.
- When defined:
  - An internal counter counts clk_in cycles since the last pix_ce and is cleared on each pix_ce.
  - When the count exceeds CE_TIMEOUT, ce_err sets to 1 and stays set until reset.
  - The counter saturates and does not wrap.
  - The first strobe after reset is exempt: the monitor arms on the first pix_ce.
- When undefined: no monitor logic is built and ce_err is a constant 0. Timing behaviour is otherwise identical.

Test Plan:
- Reset, then pix_ce every 4th cycle; first strobe → h=0, v=0, de=1, line_start=frame_start=1 for exactly one clk_in cycle.
- Run one full line → hsync=0 for exactly 96 strobes, starting at h=656 and releasing at h=752; de=0 from h=640 to h=799; line_start again at the h 799→0 wrap.
- Run one full frame (420000 strobes) → vsync=0 on v=490,491 only; de never high for v≥480; next frame_start exactly 420000 strobes after the first.
- Hold pix_ce=0 for 50 cycles mid-line at h=300 → h_count, v_count, hsync, vsync, de unchanged; no line_start/frame_start pulses; then resume normally.
- Assert reset for one cycle at (h=300, v=200) → next cycle h=799, v=524, hsync=vsync=1, de=0; next strobe → (0,0) with frame_start.
- VGA_TIMING_CE_MONITOR_EN defined, CE_TIMEOUT=8: strobe gaps of 8 cycles → ce_err stays 0; one gap of 10 cycles → ce_err=1 and remains 1 across further normal strobes until reset.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing (counters, syncs, display enable, line/frame pulses) driven by
// a pixel-rate strobe in the clk_in domain. Define VGA_TIMING_CE_MONITOR_EN to build the ce_err monitor.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          SYNC_POL   = 1'b0,
  parameter int unsigned CNT_W      = 10,
  parameter int unsigned CE_TIMEOUT = 8
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             pix_ce,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line_start,
  output logic             frame_start,
  output logic             ce_err
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam longint     MAX_CNT = longint'(1) << CNT_W;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  // Decode bounds carry one extra bit so an end bound equal to 2**CNT_W stays representable
  localparam logic [CNT_W:0] H_ACT_X  = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0] HS_BEG_X = (CNT_W+1)'(H_ACTIVE + H_FP);
  localparam logic [CNT_W:0] HS_END_X = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W:0] V_ACT_X  = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W:0] VS_BEG_X = (CNT_W+1)'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0] VS_END_X = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

  if (longint'(H_TOTAL) > MAX_CNT) begin : g_h_total_chk
    $error("vga_timing_gen: H_TOTAL does not fit in CNT_W bits");
  end
  if (longint'(V_TOTAL) > MAX_CNT) begin : g_v_total_chk
    $error("vga_timing_gen: V_TOTAL does not fit in CNT_W bits");
  end
  if (CE_TIMEOUT == 0) begin : g_timeout_chk
    $error("vga_timing_gen: CE_TIMEOUT must be at least 1");
  end

  logic [CNT_W-1:0] r_h_count;
  logic [CNT_W-1:0] r_v_count;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_de;
  logic             r_line_start;
  logic             r_frame_start;

  logic [CNT_W-1:0] w_h_next;
  logic [CNT_W-1:0] w_v_next;
  logic [CNT_W:0]   w_h_ext;
  logic [CNT_W:0]   w_v_ext;
  logic             w_hs_act;
  logic             w_vs_act;
  logic             w_de_next;
  logic             w_h_wrap;

  always_comb begin
    w_h_next = r_h_count;
    w_v_next = r_v_count;
    w_h_wrap = 1'b0;
    if (pix_ce) begin
      if (r_h_count == H_LAST) begin
        w_h_next = '0;
        w_h_wrap = 1'b1;
        if (r_v_count == V_LAST) w_v_next = '0;
        else                     w_v_next = r_v_count + CNT_W'(1);
      end else begin
        w_h_next = r_h_count + CNT_W'(1);
      end
    end
  end

  // Levels are decoded from the next-state counters so they register on the same edge
  always_comb begin
    w_h_ext   = {1'b0, w_h_next};
    w_v_ext   = {1'b0, w_v_next};
    w_hs_act  = (w_h_ext >= HS_BEG_X) && (w_h_ext < HS_END_X);
    w_vs_act  = (w_v_ext >= VS_BEG_X) && (w_v_ext < VS_END_X);
    w_de_next = (w_h_ext < H_ACT_X) && (w_v_ext < V_ACT_X);
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_h_count     <= H_LAST;
      r_v_count     <= V_LAST;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_de          <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_h_count     <= w_h_next;
      r_v_count     <= w_v_next;
      r_hsync       <= w_hs_act ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= w_vs_act ? SYNC_POL : ~SYNC_POL;
      r_de          <= w_de_next;
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_h_wrap && (w_v_next == '0);
    end
  end

  assign h_count     = r_h_count;
  assign v_count     = r_v_count;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

`ifdef VGA_TIMING_CE_MONITOR_EN
  localparam int unsigned    GAP_W   = $clog2(CE_TIMEOUT + 2);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(CE_TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_LIM = GAP_W'(CE_TIMEOUT);

  typedef enum logic [0:0] {
    MON_IDLE,
    MON_ARMED
  } mon_state_t;

  mon_state_t       r_mon_state;
  mon_state_t       w_mon_state_next;
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] w_gap_next;
  logic             r_ce_err;
  logic             w_ce_err_next;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_mon_state <= MON_IDLE;
      r_gap       <= '0;
      r_ce_err    <= 1'b0;
    end else begin
      r_mon_state <= w_mon_state_next;
      r_gap       <= w_gap_next;
      r_ce_err    <= w_ce_err_next;
    end
  end

  // Gap count saturates one past the limit; the first strobe after reset only arms the monitor
  always_comb begin
    w_mon_state_next = r_mon_state;
    w_gap_next       = r_gap;
    w_ce_err_next    = r_ce_err;
    if (pix_ce) begin
      w_mon_state_next = MON_ARMED;
      w_gap_next       = '0;
    end else if ((r_mon_state == MON_ARMED) && (r_gap != GAP_MAX)) begin
      w_gap_next = r_gap + GAP_W'(1);
    end
    if (w_gap_next > GAP_LIM) w_ce_err_next = 1'b1;
  end

  assign ce_err = r_ce_err;
`else
  assign ce_err = 1'b0;
`endif

endmodule
